// File: rtl/keccak_pkg.sv
// Shared Keccak constants, the absorb/squeeze lane interleave and the squeeze FSM states.
package keccak_pkg;

    localparam int LANE_W     = 64;
    localparam int STATE_W    = 1600;
    localparam int RATE       = 1088;
    localparam int RATE_WORDS = RATE / LANE_W;

    // State slot holding linear rate word i; the absorb stage writes with the same map.
    function automatic int lane_slot(input int i);
        return 24 - 5 * (i % 5) - (i / 5);
    endfunction

    typedef enum logic [1:0] {
        SQ_IDLE      = 2'd0,
        SQ_STREAM    = 2'd1,
        SQ_WAIT_PERM = 2'd2
    } sq_state_e;

endpackage

// File: rtl/keccak_lane_unmap.sv
// Combinational de-interleave: lane-ordered state array to linear rate words.
module keccak_lane_unmap
    import keccak_pkg::*;
(
    input  logic [STATE_W-1:0] state_in,
    output logic [RATE-1:0]    rate_out
);

    for (genvar i = 0; i < RATE_WORDS; i++) begin : g_word
        assign rate_out[i*LANE_W +: LANE_W] = state_in[lane_slot(i)*LANE_W +: LANE_W];
    end

    // Capacity lanes are intentionally dropped here.
    logic unused_capacity;
    assign unused_capacity = ^state_in;

endmodule

// File: rtl/keccak_squeeze.sv
// Squeeze stage: captures the rate part of a permuted state and streams the digest
// as 64-bit words, requesting further permutations when a rate block is exhausted.
module keccak_squeeze
    import keccak_pkg::*;
#(
    parameter int OUT_WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [STATE_W-1:0]  state_in,
    output logic                perm_req,
    input  logic                perm_done,
    output logic [LANE_W-1:0]   dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                dout_last,
    output logic                busy,
    output logic                done
);

    localparam logic [7:0] LAST_CNT = 8'(OUT_WORDS - 1);
    localparam logic [4:0] LAST_IDX = 5'(RATE_WORDS - 1);

    sq_state_e       state_q, state_d;
    logic [RATE-1:0] rate_vec;
    logic [RATE-1:0] buf_q;
    logic [4:0]      word_idx_q;
    logic [7:0]      out_cnt_q;
    logic            perm_req_q, done_q;
    logic            capture, handshake, is_last;

    keccak_lane_unmap u_unmap (
        .state_in (state_in),
        .rate_out (rate_vec)
    );

    // Handshake: a word transfers on every rising edge where dout_valid and dout_ready
    // are both high; while dout_valid is high and dout_ready low, dout/dout_last hold.
    assign dout_valid = (state_q == SQ_STREAM);
    assign handshake  = dout_valid & dout_ready;
    assign is_last    = (out_cnt_q == LAST_CNT);
    assign dout       = dout_valid ? buf_q[word_idx_q*LANE_W +: LANE_W] : '0;
    assign dout_last  = dout_valid & is_last;
    assign busy       = (state_q != SQ_IDLE);
    assign perm_req   = perm_req_q;
    assign done       = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            SQ_IDLE: begin
                if (start) begin
                    state_d = SQ_STREAM;
                    capture = 1'b1;
                end
            end
            SQ_STREAM: begin
                if (handshake) begin
                    if (is_last) begin
                        state_d = SQ_IDLE;
                    end else if (word_idx_q == LAST_IDX) begin
                        state_d = SQ_WAIT_PERM;
                    end
                end
            end
            SQ_WAIT_PERM: begin
                if (perm_done) begin
                    state_d = SQ_STREAM;
                    capture = 1'b1;
                end
            end
            default: state_d = SQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '0;
            word_idx_q <= '0;
            out_cnt_q  <= '0;
            perm_req_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            perm_req_q <= handshake & ~is_last & (word_idx_q == LAST_IDX);
            done_q     <= handshake & is_last;
            if (capture) begin
                buf_q      <= rate_vec;
                word_idx_q <= '0;
            end else if (handshake) begin
                word_idx_q <= word_idx_q + 5'd1;
            end
            // The output count only restarts on a fresh start, not on a recapture.
            if (state_q == SQ_IDLE && start) begin
                out_cnt_q <= '0;
            end else if (handshake) begin
                out_cnt_q <= out_cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_keccak_squeeze.sv
// Directed bench for keccak_squeeze: three instances (4, 20 and 17 output words),
// a transaction-level model with an expected-word queue, and literal pin checks.
module tb_keccak_squeeze;

    logic          clk;
    logic          rst_n;
    logic [1599:0] state_in;
    logic          perm_done;
    logic          dout_ready;
    logic          start_v      [3];
    logic          perm_req_v   [3];
    logic [63:0]   dout_v       [3];
    logic          dout_valid_v [3];
    logic          dout_last_v  [3];
    logic          busy_v       [3];
    logic          done_v       [3];

    int checks = 0;
    int errors = 0;
    int sel    = 0;
    int totals [3] = '{4, 20, 17};

    keccak_squeeze #(.OUT_WORDS(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .state_in(state_in),
        .perm_req(perm_req_v[0]), .perm_done(perm_done), .dout(dout_v[0]),
        .dout_valid(dout_valid_v[0]), .dout_ready(dout_ready),
        .dout_last(dout_last_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    keccak_squeeze #(.OUT_WORDS(20)) u_w20 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .state_in(state_in),
        .perm_req(perm_req_v[1]), .perm_done(perm_done), .dout(dout_v[1]),
        .dout_valid(dout_valid_v[1]), .dout_ready(dout_ready),
        .dout_last(dout_last_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    keccak_squeeze #(.OUT_WORDS(17)) u_w17 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .state_in(state_in),
        .perm_req(perm_req_v[2]), .perm_done(perm_done), .dout(dout_v[2]),
        .dout_valid(dout_valid_v[2]), .dout_ready(dout_ready),
        .dout_last(dout_last_v[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic int slot_of(input int i);
        return 24 - 5 * (i % 5) - (i / 5);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_state(input logic [63:0] base);
        for (int k = 0; k < 25; k++) state_in[64*k +: 64] = base + 64'(k);
    endtask

    task automatic wait_done(input int bound, input string name);
        int n;
        n = 0;
        while (!done_v[sel] && n < bound) begin
            tick();
            n++;
        end
        check(name, {63'd0, done_v[sel]}, 64'd1);
    endtask

    // ---------------- scoreboard / model ----------------
    logic [63:0] exp_q[$];
    bit m_busy, m_valid, m_wait, done_exp, perm_exp;
    int m_cnt;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < 3; j++) begin
                check("reset_outputs",
                      {dout_v[j] | {perm_req_v[j], dout_valid_v[j], dout_last_v[j], busy_v[j], done_v[j]}},
                      64'd0);
            end
            m_busy = 0; m_valid = 0; m_wait = 0; done_exp = 0; perm_exp = 0; m_cnt = 0;
            exp_q.delete();
        end else begin
            for (int j = 0; j < 3; j++) begin
                if (j != sel) begin
                    check("idle_instance",
                          {60'd0, busy_v[j], dout_valid_v[j], done_v[j], perm_req_v[j]}, 64'd0);
                end
            end
            check("busy",       {63'd0, busy_v[sel]},       {63'd0, m_busy});
            check("dout_valid", {63'd0, dout_valid_v[sel]}, {63'd0, m_valid});
            check("done",       {63'd0, done_v[sel]},       {63'd0, done_exp});
            check("perm_req",   {63'd0, perm_req_v[sel]},   {63'd0, perm_exp});
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    check("exp_queue_empty", 64'd0, 64'd1);
                end else begin
                    check("dout", dout_v[sel], exp_q[0]);
                end
                check("dout_last", {63'd0, dout_last_v[sel]},
                      {63'd0, (m_cnt == totals[sel] - 1)});
            end
            // Advance the model using the inputs the next rising edge will sample.
            done_exp = 0;
            perm_exp = 0;
            if (m_valid && dout_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_cnt++;
                if (m_cnt == totals[sel]) begin
                    m_busy = 0; m_valid = 0; done_exp = 1;
                end else if (m_cnt % 17 == 0) begin
                    m_valid = 0; m_wait = 1; perm_exp = 1;
                end
            end else if (!m_busy && start_v[sel]) begin
                m_busy = 1; m_valid = 1; m_cnt = 0;
            end else if (m_wait && perm_done) begin
                m_wait = 0; m_valid = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int pat [4] = '{1, 0, 0, 1};
        rst_n = 1'b0;
        perm_done = 1'b0;
        dout_ready = 1'b0;
        state_in = '0;
        for (int j = 0; j < 3; j++) start_v[j] = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Test 1: 4 words, ready always high, literal pins.
        sel = 0;
        fill_state(64'h1000);
        for (int i = 0; i < 4; i++) exp_q.push_back(64'h1000 + 64'(slot_of(i)));
        dout_ready = 1'b1;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        check("t1_word0", dout_v[0], 64'h1018);
        tick();
        check("t1_word1", dout_v[0], 64'h1013);
        tick();
        check("t1_word2", dout_v[0], 64'h100E);
        tick();
        check("t1_word3", dout_v[0], 64'h1009);
        check("t1_last", {63'd0, dout_last_v[0]}, 64'd1);
        tick();
        check("t1_done", {63'd0, done_v[0]}, 64'd1);
        check("t1_busy_after", {63'd0, busy_v[0]}, 64'd0);
        tick();

        // Test 2: ready pattern 1,0,0,1 and ignored start pulses.
        for (int i = 0; i < 4; i++) exp_q.push_back(64'h1000 + 64'(slot_of(i)));
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        n = 0;
        while (!done_v[0] && n < 40) begin
            dout_ready = pat[n % 4][0];
            start_v[0] = (n == 2 || n == 5);
            tick();
            n++;
        end
        start_v[0] = 1'b0;
        check("t2_done", {63'd0, done_v[0]}, 64'd1);
        check("t2_queue_drained", 64'(exp_q.size()), 64'd0);
        dout_ready = 1'b1;
        tick();

        // Test 3: 20 words across a permutation; perm_done in IDLE and STREAM is ignored.
        sel = 1;
        perm_done = 1'b1;
        tick();
        perm_done = 1'b0;
        for (int i = 0; i < 17; i++) exp_q.push_back(64'h1000 + 64'(slot_of(i)));
        for (int i = 0; i < 3; i++)  exp_q.push_back(64'h2000 + 64'(slot_of(i)));
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        tick();
        perm_done = 1'b1;
        tick();
        perm_done = 1'b0;
        n = 0;
        while (!perm_req_v[1] && n < 40) begin
            tick();
            n++;
        end
        check("t3_perm_req", {63'd0, perm_req_v[1]}, 64'd1);
        repeat (3) tick();
        check("t3_wait_valid", {63'd0, dout_valid_v[1]}, 64'd0);
        fill_state(64'h2000);
        tick();
        perm_done = 1'b1;
        tick();
        perm_done = 1'b0;
        check("t3_after_perm", dout_v[1], 64'h2018);
        wait_done(20, "t3_done");
        check("t3_queue_drained", 64'(exp_q.size()), 64'd0);
        tick();

        // Test 4: round trip with an absorbed state, capacity lanes carry junk.
        sel = 2;
        fill_state(64'hC0DE_0000);
        for (int i = 0; i < 17; i++) begin
            state_in[64*slot_of(i) +: 64] = 64'hA0 + 64'(i);
            exp_q.push_back(64'hA0 + 64'(i));
        end
        start_v[2] = 1'b1;
        tick();
        start_v[2] = 1'b0;
        check("t4_word0", dout_v[2], 64'hA0);
        wait_done(40, "t4_done");
        check("t4_queue_drained", 64'(exp_q.size()), 64'd0);
        tick();

        // Test 5: reset after the second handshake, then a clean restart.
        sel = 0;
        fill_state(64'h1000);
        for (int i = 0; i < 4; i++) exp_q.push_back(64'h1000 + 64'(slot_of(i)));
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_reset_valid", {63'd0, dout_valid_v[0]}, 64'd0);
        check("t5_reset_dout", dout_v[0], 64'd0);
        check("t5_reset_busy", {63'd0, busy_v[0]}, 64'd0);
        tick();
        check("t5_no_done", {63'd0, done_v[0]}, 64'd0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) exp_q.push_back(64'h1000 + 64'(slot_of(i)));
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        check("t5_restart_word0", dout_v[0], 64'h1018);
        wait_done(20, "t5_done");
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keccak_squeeze.md
Name: keccak_squeeze

Overview:
- Squeeze-side counterpart of the Keccak absorb/padding stage.
- Takes the 1600-bit lane-ordered state array after a permutation and undoes the absorb lane interleave to recover linear rate words.
- Streams the digest out as 64-bit words over a valid/ready handshake.
- When the requested output exceeds one rate block, requests a further permutation and continues squeezing.

Parameters:
- LANE_W, 64, lane width in bits.
- RATE, 1088, rate in bits; RATE_WORDS = RATE/LANE_W = 17.
- OUT_WORDS, 4, digest length in 64-bit words; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse: state_in holds a squeezable state
- state_in  in  1600  lane-ordered state array; slot k = state_in[64k+:64]
- perm_req  out  1  single-cycle pulse requesting another permutation of the state
- perm_done  in  1  single-cycle pulse: state_in now holds the permuted state
- dout  out  64  current output word
- dout_valid  out  1  dout is valid
- dout_ready  in  1  consumer accepts dout
- dout_last  out  1  high with the final word of the digest
- busy  out  1  high whenever the FSM is not in IDLE
- done  out  1  single-cycle pulse, one cycle after the last handshake

Behaviour:
- Lane mapping: linear rate word i (0..16) = state_in slot 24 - 5*(i%5) - (i/5).
  - Example: word0 = slot 24, word1 = slot 19, word5 = slot 23.
- Capture: all 17 rate words are de-interleaved and registered into a 1088-bit buffer. Capacity lanes are never output.
- FSM states: IDLE, STREAM, WAIT_PERM.
- IDLE:
  - start=1 → capture buffer, word_idx=0, out_cnt=0 → STREAM.
  - dout_valid rises in the cycle after start (latency 1).
- STREAM:
  - dout_valid=1, dout=buffer word word_idx, dout_last=(out_cnt==OUT_WORDS-1).
  - A handshake (dout_valid & dout_ready) increments out_cnt, then:
    - if last word → IDLE; done pulses next cycle.
    - else if word_idx==RATE_WORDS-1 → perm_req pulses next cycle → WAIT_PERM.
    - else word_idx+1.
- WAIT_PERM:
  - dout_valid=0.
  - perm_done=1 → recapture buffer from state_in, word_idx=0 → STREAM.
- Backpressure: with dout_ready=0, dout, dout_valid and dout_last hold stable. No word is dropped or duplicated.
- start is ignored while busy=1.
- perm_done is ignored outside WAIT_PERM.
- start and perm_done in the same cycle: only the one relevant to the current state is acted on.
- out_cnt is 8 bits wide; no wrap-around is possible given the legal OUT_WORDS range.
- Reset values: all outputs 0, FSM=IDLE, buffer=0, counters=0.
- Reset asserted mid-stream aborts the transfer immediately; no done and no perm_req are produced.

Decomposition:
- Shared package keccak_pkg:
  - constants LANE_W, STATE_W=1600, RATE, RATE_WORDS
  - a function lane_slot(i) returning 24-5*(i%5)-(i/5), shared with the absorb/padding stage
  - an FSM state enum
- One natural sub-module: keccak_lane_unmap. It is purely combinational: state array in, 1088-bit linear rate vector out.
- The FSM, counters and buffer stay in keccak_squeeze.

Test Plan:
- Slot k of state_in = 0x1000+k, OUT_WORDS=4, dout_ready=1, start pulse:
  - dout = 0x1018, 0x1013, 0x100E, 0x1009 on 4 consecutive cycles starting 1 cycle after start.
  - dout_last on the 4th word; done one cycle later; busy then 0.
- Same stimulus, dout_ready toggled 1,0,0,1,...:
  - dout stays stable while stalled; identical 4-word sequence.
  - start pulses issued during the transfer are ignored.
- OUT_WORDS=20:
  - 17 words in mapping order, then perm_req pulse, dout_valid=0.
  - state_in changed to slot k = 0x2000+k, then perm_done:
    - next words are 0x2018, 0x2013, 0x200E; dout_last on the 3rd; done follows.
- Round trip with the padding stage (check=0, state=0, datain = words 0xA0..0xB0):
  - feed the padding stage's A output to state_in with OUT_WORDS=17.
  - dout = 0xA0..0xB0 in order.
- rst_n low after the 2nd handshake:
  - all outputs 0 immediately; no done.
  - a new start afterwards restarts from word 0.
- perm_done pulsed in IDLE and in STREAM: no effect on the sequence or the counters.
